// File: rtl/xbar_l2_mem_bank_array.sv
// ============================================================================
// Module   : xbar_l2_mem_bank_array
// Brief    : N-channel L2 memory-bank responder, one private bank per XBAR
//            channel, byte-enable stores, fixed-latency registered responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbar_l2_mem_bank_array #(
  parameter int N_CH    = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 9,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          data_req_i,
  input  logic [N_CH*ADDR_W-1:0]   data_add_i,
  input  logic [N_CH-1:0]          data_wen_i,
  input  logic [N_CH*DATA_W-1:0]   data_wdata_i,
  input  logic [N_CH*DATA_W/8-1:0] data_be_i,
  input  logic [N_CH*ID_W-1:0]     data_ID_i,
  output logic [N_CH*DATA_W-1:0]   data_r_rdata_o,
  output logic [N_CH-1:0]          data_r_valid_o,
  output logic [N_CH*ID_W-1:0]     data_r_ID_o,
  output logic [N_CH-1:0]          data_r_err_o,
  output logic [15:0]              err_cnt_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $fatal(1, "LATENCY must be in 1..4");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $fatal(1, "DATA_W must be a multiple of 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "DEPTH must be a power of 2");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_bad_range
    $fatal(1, "DEPTH exceeds the address space");
  end

  logic [N_CH-1:0] w_err;
  logic [N_CH-1:0] w_err_req;
  logic [16:0]     w_nerr;
  logic [16:0]     w_cnt_sum;
  logic [15:0]     err_cnt_d;
  logic [15:0]     err_cnt_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [ADDR_W-1:0] w_add;
    logic [IDX_W-1:0]  w_idx;
    logic              w_store;
    logic              w_load;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [ID_W-1:0]    id_q    [LATENCY];
    logic [DATA_W-1:0]  rdata_q [LATENCY];

    assign w_add = data_add_i[c*ADDR_W +: ADDR_W];
    assign w_idx = w_add[IDX_W-1:0];

    if (IDX_W < ADDR_W) begin : g_range
      assign w_err[c] = |w_add[ADDR_W-1:IDX_W];
    end else begin : g_full
      assign w_err[c] = 1'b0;
    end

    assign w_store = data_req_i[c] & ~data_wen_i[c] & ~w_err[c];
    assign w_load  = data_req_i[c] &  data_wen_i[c] & ~w_err[c];

    // Bank storage is intentionally not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
      if (w_store) begin
        for (int b = 0; b < BE_W; b++) begin
          if (data_be_i[c*BE_W + b]) begin
            mem_q[w_idx][b*8 +: 8] <= data_wdata_i[c*DATA_W + b*8 +: 8];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        err_q <= '0;
        for (int s = 0; s < LATENCY; s++) begin
          id_q[s]    <= '0;
          rdata_q[s] <= '0;
        end
      end else begin
        vld_q[0]   <= data_req_i[c];
        err_q[0]   <= data_req_i[c] & w_err[c];
        id_q[0]    <= data_req_i[c] ? data_ID_i[c*ID_W +: ID_W] : '0;
        rdata_q[0] <= w_load ? mem_q[w_idx] : '0;
        for (int s = 1; s < LATENCY; s++) begin
          vld_q[s]   <= vld_q[s-1];
          err_q[s]   <= err_q[s-1];
          id_q[s]    <= id_q[s-1];
          rdata_q[s] <= rdata_q[s-1];
        end
      end
    end

    assign data_r_valid_o[c]                = vld_q[LATENCY-1];
    assign data_r_err_o[c]                  = err_q[LATENCY-1];
    assign data_r_ID_o[c*ID_W +: ID_W]      = id_q[LATENCY-1];
    assign data_r_rdata_o[c*DATA_W +: DATA_W] = rdata_q[LATENCY-1];
  end

  assign w_err_req = data_req_i & w_err;

  always_comb begin
    w_nerr = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_nerr = w_nerr + 17'(w_err_req[i]);
    end
  end

  // 17-bit sum so the carry out detects saturation.
  assign w_cnt_sum = {1'b0, err_cnt_q} + w_nerr;
  assign err_cnt_d = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_xbar_l2_mem_bank_array.sv
// ============================================================================
// Module   : tb_xbar_l2_mem_bank_array
// Brief    : Self-checking bench: vector table, back-to-back loads, reset
//            mid-flight and error-counter saturation, scoreboard-compared.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xbar_l2_mem_bank_array;

  localparam int N_CH = 4;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int IW   = 9;
  localparam int DEP  = 256;
  localparam int LAT  = 3;
  localparam int BW   = DW / 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_CH-1:0]      data_req_i;
  logic [N_CH*AW-1:0]   data_add_i;
  logic [N_CH-1:0]      data_wen_i;
  logic [N_CH*DW-1:0]   data_wdata_i;
  logic [N_CH*BW-1:0]   data_be_i;
  logic [N_CH*IW-1:0]   data_ID_i;
  logic [N_CH*DW-1:0]   data_r_rdata_o;
  logic [N_CH-1:0]      data_r_valid_o;
  logic [N_CH*IW-1:0]   data_r_ID_o;
  logic [N_CH-1:0]      data_r_err_o;
  logic [15:0]          err_cnt_o;

  xbar_l2_mem_bank_array #(
    .N_CH(N_CH), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .DEPTH(DEP), .LATENCY(LAT)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_req_i     (data_req_i),
    .data_add_i     (data_add_i),
    .data_wen_i     (data_wen_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_ID_i      (data_ID_i),
    .data_r_rdata_o (data_r_rdata_o),
    .data_r_valid_o (data_r_valid_o),
    .data_r_ID_o    (data_r_ID_o),
    .data_r_err_o   (data_r_err_o),
    .err_cnt_o      (err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic        wen;
    logic [11:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [8:0]  id;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          ch;
    logic [8:0]  id;
    logic [31:0] rdata;
    logic        err;
    longint      due;
  } exp_t;

  vec_t        vecs [18];
  exp_t        sb_q [$];
  logic [31:0] mdl [N_CH][DEP];
  longint      cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
    end
  endtask

  // Idle channels carry random garbage so a non-requesting channel must ignore it.
  task automatic idle_all();
    data_req_i   = '0;
    data_wen_i   = 4'($urandom());
    data_add_i   = 48'({$urandom(), $urandom()});
    data_wdata_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    data_be_i    = 16'($urandom());
    data_ID_i    = 36'({$urandom(), $urandom()});
  endtask

  task automatic set_ch(input int c, input logic wen, input logic [11:0] add,
                        input logic [31:0] wd, input logic [3:0] be, input logic [8:0] id,
                        input logic [31:0] er, input logic ee);
    exp_t e;
    data_req_i[c]           = 1'b1;
    data_wen_i[c]           = wen;
    data_add_i[c*AW +: AW]  = add;
    data_wdata_i[c*DW +: DW] = wd;
    data_be_i[c*BW +: BW]   = be;
    data_ID_i[c*IW +: IW]   = id;
    e.ch = c; e.id = id; e.rdata = er; e.err = ee; e.due = cyc + LAT;
    sb_q.push_back(e);
    if (!wen && add < 12'(DEP)) begin
      for (int b = 0; b < BW; b++) begin
        if (be[b]) mdl[c][add[7:0]][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon();
    exp_t       e;
    logic [3:0] seen;
    seen = '0;
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL resp_missing ch%0d: got no response, required ID %0h at cycle %0d",
               e.ch, e.id, e.due);
    end
    while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      seen[e.ch] = 1'b1;
      check($sformatf("valid_ch%0d", e.ch), 64'(data_r_valid_o[e.ch]), 64'd1);
      check($sformatf("id_ch%0d", e.ch), 64'(data_r_ID_o[e.ch*IW +: IW]), 64'(e.id));
      check($sformatf("rdata_ch%0d", e.ch), 64'(data_r_rdata_o[e.ch*DW +: DW]), 64'(e.rdata));
      check($sformatf("err_ch%0d", e.ch), 64'(data_r_err_o[e.ch]), 64'(e.err));
    end
    for (int c = 0; c < N_CH; c++) begin
      if (!seen[c]) begin
        check($sformatf("idle_ch%0d", c),
              64'({data_r_valid_o[c], data_r_err_o[c], data_r_ID_o[c*IW +: IW],
                   data_r_rdata_o[c*DW +: DW]}), 64'd0);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{0, 1'b0, 12'h010, 32'hDEADBEEF, 4'hF, 9'h005, 32'h0,        1'b0};
    vecs[1]  = '{0, 1'b1, 12'h010, 32'h0,        4'h0, 9'h006, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{0, 1'b0, 12'h020, 32'hDEADBEEF, 4'hF, 9'h007, 32'h0,        1'b0};
    vecs[3]  = '{0, 1'b0, 12'h020, 32'h11223344, 4'h5, 9'h008, 32'h0,        1'b0};
    vecs[4]  = '{0, 1'b1, 12'h020, 32'h0,        4'h0, 9'h009, 32'hDE22BE44, 1'b0};
    vecs[5]  = '{0, 1'b0, 12'h000, 32'hCAFEF00D, 4'hF, 9'h00A, 32'h0,        1'b0};
    vecs[6]  = '{0, 1'b0, 12'h100, 32'h12345678, 4'hF, 9'h00B, 32'h0,        1'b1};
    vecs[7]  = '{0, 1'b1, 12'h100, 32'h0,        4'h0, 9'h00C, 32'h0,        1'b1};
    vecs[8]  = '{0, 1'b1, 12'h000, 32'h0,        4'h0, 9'h00D, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{3, 1'b0, 12'h0FF, 32'h01020304, 4'hF, 9'h1FF, 32'h0,        1'b0};
    vecs[10] = '{3, 1'b0, 12'h0FF, 32'hFFFFFFFF, 4'h8, 9'h100, 32'h0,        1'b0};
    vecs[11] = '{3, 1'b1, 12'h0FF, 32'h0,        4'h0, 9'h101, 32'hFF020304, 1'b0};
    vecs[12] = '{2, 1'b0, 12'h005, 32'h55667788, 4'hF, 9'h033, 32'h0,        1'b0};
    vecs[13] = '{2, 1'b0, 12'h005, 32'h00000000, 4'h0, 9'h034, 32'h0,        1'b0};
    vecs[14] = '{2, 1'b1, 12'h005, 32'h0,        4'h0, 9'h035, 32'h55667788, 1'b0};
    vecs[15] = '{1, 1'b1, 12'hFFF, 32'h0,        4'h0, 9'h1AB, 32'h0,        1'b1};
    vecs[16] = '{1, 1'b0, 12'h0FF, 32'hAABBCCDD, 4'hF, 9'h000, 32'h0,        1'b0};
    vecs[17] = '{1, 1'b1, 12'h0FF, 32'h0,        4'h0, 9'h001, 32'hAABBCCDD, 1'b0};

    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none

    rst_n = 1'b0;
    idle_all();
    repeat (3) step();
    check("reset_err_cnt", 64'(err_cnt_o), 64'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors: store/load ordering, byte enables, out-of-range.
    for (int i = 0; i < 18; i++) begin
      idle_all();
      set_ch(vecs[i].ch, vecs[i].wen, vecs[i].add, vecs[i].wdata, vecs[i].be,
             vecs[i].id, vecs[i].exp_rdata, vecs[i].exp_err);
      step();
    end
    check("err_cnt_after_table", 64'(err_cnt_o), 64'd3);

    // Back-to-back loads on every channel, preceded by stores of random data.
    for (int i = 0; i < 20; i++) begin
      idle_all();
      for (int c = 0; c < N_CH; c++)
        set_ch(c, 1'b0, 12'h040 + 12'(i), $urandom(), 4'hF, 9'(100 + i), 32'h0, 1'b0);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      idle_all();
      for (int c = 0; c < N_CH; c++)
        set_ch(c, 1'b1, 12'h040 + 12'(i), 32'h0, 4'h0, 9'(i), mdl[c][8'h40 + 8'(i)], 1'b0);
      step();
    end

    // Reset while two loads are in flight: both responses must vanish.
    idle_all();
    set_ch(0, 1'b1, 12'h010, 32'h0, 4'h0, 9'h0E0, 32'h0, 1'b0);
    step();
    idle_all();
    set_ch(0, 1'b1, 12'h020, 32'h0, 4'h0, 9'h0E1, 32'h0, 1'b0);
    step();
    idle_all();
    rst_n = 1'b0;
    sb_q.delete();
    step();
    rst_n = 1'b1;
    check("err_cnt_after_reset", 64'(err_cnt_o), 64'd0);
    repeat (LAT + 2) step();
    idle_all();
    set_ch(0, 1'b1, 12'h010, 32'h0, 4'h0, 9'h0E2, 32'hDEADBEEF, 1'b0);
    set_ch(3, 1'b1, 12'h0FF, 32'h0, 4'h0, 9'h0E3, 32'hFF020304, 1'b0);
    step();

    // Saturation: 4 errored requests per cycle for 16385 cycles.
    for (int n = 0; n < 16385; n++) begin
      idle_all();
      for (int c = 0; c < N_CH; c++)
        set_ch(c, 1'($urandom()), {4'($urandom_range(1, 15)), 8'($urandom())},
               $urandom(), 4'($urandom()), 9'($urandom()), 32'h0, 1'b1);
      step();
      if (n == 15999) check("err_cnt_mid", 64'(err_cnt_o), 64'd64000);
    end
    check("err_cnt_saturated", 64'(err_cnt_o), 64'hFFFF);
    idle_all();
    step();
    check("err_cnt_hold", 64'(err_cnt_o), 64'hFFFF);

    repeat (LAT + 2) step();
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
